re_mapper_multi_dmrs: RTL and testbench

- Parametrised successor resource-element mapper for the PUSCH receive/transmit grid.
- For each OFDM symbol in an allocated range it writes one symbol row of RE-grid memory:
  - DMRS symbols, selected by a per-slot bitmask, get the DMRS stream on a configurable comb with zeros elsewhere.
  - All other symbols get the FFT/data stream.
- Sits between the DMRS generator / FFT output buffers and the RE-grid RAM. Uses valid/ready input handshakes instead of free-running counters.

---
 rtl/re_mapper_multi_dmrs.sv | 150 +++++++++++++++
 tb/tb_re_mapper_multi_dmrs.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/re_mapper_multi_dmrs.sv
// re_mapper_multi_dmrs: maps DMRS (combed) and data/FFT streams into RE-grid symbol rows.
// Each allocated symbol row gets N_rb*12 writes; DMRS rows take the DMRS stream on a comb.
module re_mapper_multi_dmrs #(
  parameter int DATA_W     = 18,
  parameter int DMRS_W     = 9,
  parameter int DMRS_SHIFT = 0,
  parameter int TOTAL_SC   = 1200,
  parameter int ADDR_W     = 11
) (
  input  logic                     CLK_RE,
  input  logic                     RST_RE,
  input  logic                     Start,
  input  logic [ADDR_W-1:0]        N_sc,
  input  logic [6:0]               N_rb,
  input  logic [3:0]               Sym_Start,
  input  logic [3:0]               Sym_End,
  input  logic [13:0]              Dmrs_Mask,
  input  logic                     Comb_Off,
  input  logic signed [DMRS_W-1:0] Dmrs_I,
  input  logic signed [DMRS_W-1:0] Dmrs_Q,
  input  logic                     Dmrs_Valid,
  output logic                     Dmrs_Ready,
  input  logic signed [DATA_W-1:0] Data_I,
  input  logic signed [DATA_W-1:0] Data_Q,
  input  logic                     Data_Valid,
  output logic                     Data_Ready,
  output logic [DATA_W-1:0]        RE_Real,
  output logic [DATA_W-1:0]        RE_Imj,
  output logic                     RE_Valid_Out,
  output logic [ADDR_W-1:0]        Wr_addr,
  output logic [3:0]               Wr_sym,
  output logic                     Sym_Done,
  output logic                     RE_Done,
  output logic                     Cfg_Err,
  output logic                     Busy
);
  localparam int VW = ADDR_W + 2;
  typedef enum logic [2:0] {IDLE, SETUP, MAP_DMRS, MAP_DATA, FINISH} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] nsc_q, k_q, k_d;
  logic [ADDR_W:0] len_q;
  logic [3:0] ss_q, se_q, sym_q, sym_d, nsym;
  logic [13:0] mask_q;
  logic comb_q, cfg_ok, accept, reject, wr, last;
  logic [VW-1:0] len_in;
  logic [DATA_W-1:0] re_d, im_d, dmrs_re, dmrs_im;
  logic [DATA_W-1:0] re_q, im_q;
  logic valid_q, sd_q, done_q, err_q, busy_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0] wsym_q;
  // validation is done wider than the address path so oversize requests cannot wrap
  assign len_in = VW'(N_rb) * VW'(12);
  assign cfg_ok = (N_rb != 7'd0) && (VW'(N_sc) + len_in <= VW'(TOTAL_SC)) &&
                  (Sym_Start <= Sym_End) && (Sym_End <= 4'd13);
  assign accept = Start && (state_q == IDLE) && cfg_ok;
  assign reject = Start && (state_q == IDLE) && !cfg_ok;
  assign dmrs_re = DATA_W'(Dmrs_I) << DMRS_SHIFT;
  assign dmrs_im = DATA_W'(Dmrs_Q) << DMRS_SHIFT;
  assign last = {1'b0, k_q} == len_q - 1'b1;
  assign nsym = sym_q + 4'd1;
  assign Dmrs_Ready = (state_q == MAP_DMRS) && (k_q[0] == comb_q);
  assign Data_Ready = (state_q == MAP_DATA);
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    sym_d = sym_q;
    wr = 1'b0;
    re_d = '0;
    im_d = '0;
    case (state_q)
      IDLE: state_d = accept ? SETUP : IDLE;
      SETUP: begin
        sym_d = ss_q;
        k_d = '0;
        state_d = mask_q[ss_q] ? MAP_DMRS : MAP_DATA;
      end
      MAP_DMRS: begin
        wr = Dmrs_Ready ? Dmrs_Valid : 1'b1;
        re_d = Dmrs_Ready ? dmrs_re : '0;
        im_d = Dmrs_Ready ? dmrs_im : '0;
      end
      MAP_DATA: begin
        wr = Data_Valid;
        re_d = Data_I;
        im_d = Data_Q;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (wr) begin
      k_d = last ? '0 : k_q + 1'b1;
      if (last) begin
        sym_d = nsym;
        state_d = (sym_q == se_q) ? FINISH : (mask_q[nsym] ? MAP_DMRS : MAP_DATA);
      end
    end
  end
  always_ff @(posedge CLK_RE or negedge RST_RE) begin
    if (!RST_RE) begin
      state_q <= IDLE;
      k_q <= '0;
      sym_q <= '0;
      nsc_q <= '0;
      len_q <= '0;
      ss_q <= '0;
      se_q <= '0;
      mask_q <= '0;
      comb_q <= 1'b0;
      re_q <= '0;
      im_q <= '0;
      valid_q <= 1'b0;
      addr_q <= '0;
      wsym_q <= '0;
      sd_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      sym_q <= sym_d;
      if (accept) begin
        nsc_q <= N_sc;
        len_q <= len_in[ADDR_W:0];
        ss_q <= Sym_Start;
        se_q <= Sym_End;
        mask_q <= Dmrs_Mask;
        comb_q <= Comb_Off;
      end
      re_q <= wr ? re_d : '0;
      im_q <= wr ? im_d : '0;
      valid_q <= wr;
      addr_q <= wr ? nsc_q + k_q : '0;
      wsym_q <= wr ? sym_q : '0;
      sd_q <= wr && last;
      done_q <= (state_q == FINISH);
      err_q <= reject;
      busy_q <= accept || (busy_q && state_q != FINISH);
    end
  end
  assign RE_Real = re_q;
  assign RE_Imj = im_q;
  assign RE_Valid_Out = valid_q;
  assign Wr_addr = addr_q;
  assign Wr_sym = wsym_q;
  assign Sym_Done = sd_q;
  assign RE_Done = done_q;
  assign Cfg_Err = err_q;
  assign Busy = busy_q;
endmodule

// File: tb/tb_re_mapper_multi_dmrs.sv
// tb_re_mapper_multi_dmrs: scoreboard bench for the RE mapper with DMRS_SHIFT=4.
module tb_re_mapper_multi_dmrs;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, comb = 1'b0;
  logic [10:0] n_sc = '0;
  logic [6:0] n_rb = '0;
  logic [3:0] sym_s = '0, sym_e = '0;
  logic [13:0] mask = '0;
  logic [8:0] dmrs_i = '0, dmrs_q = '0;
  logic dmrs_valid = 1'b0, dmrs_ready, data_valid = 1'b0, data_ready;
  logic [17:0] data_i = '0, data_q = '0, re_real, re_imj;
  logic re_valid, sym_done, re_done, cfg_err, busy;
  logic [10:0] wr_addr;
  logic [3:0] wr_sym;
  typedef struct packed {
    logic [10:0] a;
    logic [3:0] s;
    logic [17:0] r;
    logic [17:0] i;
    logic sd;
    logic last;
  } ent_t;
  ent_t sb[$];
  ent_t e;
  int tests = 0, fails = 0, dj = 0, dd = 0, vmode = 0, done_cnt = 0;
  bit hs_d = 0, hs_x = 0, exp_done = 0;

  re_mapper_multi_dmrs #(.DMRS_SHIFT(4)) dut (
    .CLK_RE(clk), .RST_RE(rst_n), .Start(start), .N_sc(n_sc), .N_rb(n_rb),
    .Sym_Start(sym_s), .Sym_End(sym_e), .Dmrs_Mask(mask), .Comb_Off(comb),
    .Dmrs_I(dmrs_i), .Dmrs_Q(dmrs_q), .Dmrs_Valid(dmrs_valid), .Dmrs_Ready(dmrs_ready),
    .Data_I(data_i), .Data_Q(data_q), .Data_Valid(data_valid), .Data_Ready(data_ready),
    .RE_Real(re_real), .RE_Imj(re_imj), .RE_Valid_Out(re_valid), .Wr_addr(wr_addr),
    .Wr_sym(wr_sym), .Sym_Done(sym_done), .RE_Done(re_done), .Cfg_Err(cfg_err), .Busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] draw(input int j, input bit q);
    return q ? 9'(50 - 3 * j) : 9'(7 * j - 256);
  endfunction

  function automatic logic [17:0] ext(input logic [8:0] v);
    logic [17:0] x;
    x = {{9{v[8]}}, v};
    return x << 4;
  endfunction

  function automatic logic [17:0] dat(input int j, input bit q);
    return q ? 18'(-7 - 5 * j) : 18'(1000 + 11 * j);
  endfunction

  initial forever begin
    @(negedge clk);
    if (hs_d) dj++;
    if (hs_x) dd++;
    dmrs_valid = vmode == 0 ? 1'b1 : vmode == 1 ? ~dmrs_valid : 1'($urandom_range(0, 1));
    data_valid = vmode == 0 ? 1'b1 : vmode == 1 ? ~data_valid : 1'($urandom_range(0, 1));
    dmrs_i = draw(dj, 0);
    dmrs_q = draw(dj, 1);
    data_i = dat(dd, 0);
    data_q = dat(dd, 1);
    #1;
    hs_d = dmrs_ready && dmrs_valid;
    hs_x = data_ready && data_valid;
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (re_done || exp_done) chk("re_done", 64'(re_done), 64'(exp_done));
      if (re_done) begin
        chk("busy_at_done", 64'(busy), 0);
        done_cnt++;
      end
      exp_done = 0;
      if (re_valid) begin
        if (sb.size() == 0) chk("extra_write", 1, 0);
        else begin
          e = sb.pop_front();
          chk("write", {wr_addr, wr_sym, re_real, re_imj, sym_done}, {e.a, e.s, e.r, e.i, e.sd});
          exp_done = e.last;
        end
      end else if (sym_done) chk("sym_done_no_write", 1, 0);
    end
  end

  task automatic start_run(input int nsc, input int nrb, input int ss, input int se,
                           input logic [13:0] m, input bit c, input int mode);
    int len, mj, mx;
    ent_t t;
    len = nrb * 12;
    mj = 0;
    mx = 0;
    for (int s = ss; s <= se; s++)
      for (int k = 0; k < len; k++) begin
        t.a = 11'(nsc + k);
        t.s = 4'(s);
        t.sd = (k == len - 1);
        t.last = t.sd && (s == se);
        if (!m[s]) begin
          t.r = dat(mx, 0);
          t.i = dat(mx, 1);
          mx++;
        end else if (k % 2 == int'(c)) begin
          t.r = ext(draw(mj, 0));
          t.i = ext(draw(mj, 1));
          mj++;
        end else begin
          t.r = '0;
          t.i = '0;
        end
        sb.push_back(t);
      end
    @(negedge clk);
    vmode = mode;
    dj = 0;
    dd = 0;
    n_sc = 11'(nsc);
    n_rb = 7'(nrb);
    sym_s = 4'(ss);
    sym_e = 4'(se);
    mask = m;
    comb = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start", 64'(busy), 1);
    chk("cfg_err_ok", 64'(cfg_err), 0);
  endtask

  task automatic wait_done();
    int c0;
    c0 = done_cnt;
    for (int i = 0; i < 40000 && done_cnt == c0; i++) @(negedge clk);
    if (done_cnt == c0) chk("timeout", 1, 0);
    chk("sb_empty", 64'(sb.size()), 0);
  endtask

  task automatic bad_start(input int nsc, input int nrb, input int ss, input int se);
    @(negedge clk);
    n_sc = 11'(nsc);
    n_rb = 7'(nrb);
    sym_s = 4'(ss);
    sym_e = 4'(se);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("cfg_err", 64'(cfg_err), 1);
    chk("busy_rej", 64'(busy), 0);
    @(negedge clk);
    chk("cfg_err_pulse", 64'(cfg_err), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #12;
    chk("reset", {dmrs_ready, data_ready, re_real, re_imj, re_valid, wr_addr, wr_sym,
                  sym_done, re_done, cfg_err, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    start_run(0, 1, 2, 3, 14'b00_0000_0000_0100, 0, 0);
    wait_done();
    start_run(100, 2, 4, 5, 14'b00_0000_0001_0000, 1, 0);
    wait_done();
    start_run(500, 3, 0, 2, 14'b00_0000_0000_0010, 0, 1);
    wait_done();
    start_run(1140, 5, 13, 13, 14'b10_0000_0000_0000, 1, 2);
    wait_done();
    start_run(0, 100, 10, 13, 14'b10_1000_0000_0000, 0, 2);
    wait_done();
    bad_start(1150, 5, 0, 0);
    bad_start(0, 1, 5, 4);
    bad_start(0, 0, 0, 0);
    bad_start(0, 1, 0, 14);
    start_run(200, 2, 7, 8, 14'b00_0001_0000_0000, 0, 0);
    repeat (5) @(negedge clk);
    n_sc = 11'd1150;
    n_rb = 7'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy_ignored", 64'(cfg_err), 0);
    wait_done();
    start_run(0, 2, 6, 7, 14'b00_0000_0100_0000, 0, 0);
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_mid", {dmrs_ready, data_ready, re_real, re_imj, re_valid, wr_addr, wr_sym,
                      sym_done, re_done, cfg_err, busy}, 0);
    sb.delete();
    exp_done = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    start_run(36, 1, 0, 1, 14'b00_0000_0000_0011, 1, 1);
    wait_done();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
